// File: rtl/ibex_pkg_pext.sv
// Shared types and constants for the P-extension (Zpn) execute-stage units.
// Holds the decoder operator encoding, packed-multiply FSM states and operator decode helpers.
`timescale 1ns/1ps
package ibex_pkg_pext;

    typedef enum logic [3:0] {
        ZPN_SMUL16  = 4'd0,
        ZPN_SMULX16 = 4'd1,
        ZPN_UMUL16  = 4'd2,
        ZPN_UMULX16 = 4'd3,
        ZPN_SMUL8   = 4'd4,
        ZPN_SMULX8  = 4'd5,
        ZPN_UMUL8   = 4'd6,
        ZPN_UMULX8  = 4'd7,
        ZPN_KHM16   = 4'd8,
        ZPN_KHMX16  = 4'd9,
        ZPN_KHM8    = 4'd10,
        ZPN_KHMX8   = 4'd11,
        ZPN_ADD16   = 4'd12,
        ZPN_SUB16   = 4'd13,
        ZPN_ADD8    = 4'd14,
        ZPN_SUB8    = 4'd15
    } zpn_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } pext_mult_state_e;

    localparam int unsigned PEXT_LANES16 = 2;
    localparam int unsigned PEXT_LANES8  = 4;

    typedef struct packed {
        logic lane16;
        logic is_signed;
        logic swap;
        logic khm;
    } pext_op_info_t;

    function automatic logic op_supported(zpn_op_e op);
        logic ok;
        unique case (op)
            ZPN_SMUL16, ZPN_SMULX16, ZPN_UMUL16, ZPN_UMULX16,
            ZPN_SMUL8,  ZPN_SMULX8,  ZPN_UMUL8,  ZPN_UMULX8,
            ZPN_KHM16,  ZPN_KHMX16,  ZPN_KHM8,   ZPN_KHMX8: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only the plain multiplies produce a register-pair result.
    function automatic logic op_wide(zpn_op_e op);
        logic w;
        unique case (op)
            ZPN_SMUL16, ZPN_SMULX16, ZPN_UMUL16, ZPN_UMULX16,
            ZPN_SMUL8,  ZPN_SMULX8,  ZPN_UMUL8,  ZPN_UMULX8: w = 1'b1;
            default:                                       w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic pext_op_info_t decode_op(zpn_op_e op);
        pext_op_info_t info;
        info = '0;
        unique case (op)
            ZPN_SMUL16:  begin info.lane16 = 1'b1; info.is_signed = 1'b1; end
            ZPN_SMULX16: begin info.lane16 = 1'b1; info.is_signed = 1'b1; info.swap = 1'b1; end
            ZPN_UMUL16:  begin info.lane16 = 1'b1; end
            ZPN_UMULX16: begin info.lane16 = 1'b1; info.swap = 1'b1; end
            ZPN_SMUL8:   begin info.is_signed = 1'b1; end
            ZPN_SMULX8:  begin info.is_signed = 1'b1; info.swap = 1'b1; end
            ZPN_UMUL8:   begin info.lane16 = 1'b0; end
            ZPN_UMULX8:  begin info.swap = 1'b1; end
            ZPN_KHM16:   begin info.lane16 = 1'b1; info.is_signed = 1'b1; info.khm = 1'b1; end
            ZPN_KHMX16:  begin info.lane16 = 1'b1; info.is_signed = 1'b1; info.khm = 1'b1; info.swap = 1'b1; end
            ZPN_KHM8:    begin info.is_signed = 1'b1; info.khm = 1'b1; end
            ZPN_KHMX8:   begin info.is_signed = 1'b1; info.khm = 1'b1; info.swap = 1'b1; end
            default:     info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/ibex_pext_lane_mul.sv
// Shared 17x17 signed lane multiplier with optional Q15/Q7 shift and saturation.
`timescale 1ns/1ps
module ibex_pext_lane_mul (
    input  logic signed [16:0] a_i,
    input  logic signed [16:0] b_i,
    input  logic               mode16_i,
    input  logic               shift_i,
    output logic        [31:0] prod_o,
    output logic               ov_o
);

    logic signed [33:0] full;
    logic signed [33:0] shifted;

    assign full    = a_i * b_i;
    assign shifted = mode16_i ? (full >>> 15) : (full >>> 7);

    // Q-format results can only overflow upward (the -1.0 * -1.0 case).
    always_comb begin
        prod_o = full[31:0];
        ov_o   = 1'b0;
        if (shift_i) begin
            if (mode16_i && (shifted > 34'sd32767)) begin
                prod_o = 32'h0000_7FFF;
                ov_o   = 1'b1;
            end else if (!mode16_i && (shifted > 34'sd127)) begin
                prod_o = 32'h0000_007F;
                ov_o   = 1'b1;
            end else begin
                prod_o = shifted[31:0];
            end
        end
    end

endmodule

// File: rtl/ibex_pext_mult.sv
// Iterative Zpn packed multiply: one SIMD lane per cycle through a single shared multiplier.
`timescale 1ns/1ps
module ibex_pext_mult
    import ibex_pkg_pext::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  zpn_op_e     operator_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        flush_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] result_o,
    output logic        wide_o,
    output logic        set_ov_o
);

    pext_mult_state_e state_q;
    zpn_op_e          op_q;
    pext_op_info_t    info_q;
    logic [1:0]       cnt_q;
    logic [31:0]      a_q, b_q;
    logic [63:0]      result_q, lane_result;
    logic             ov_q, wide_q;

    logic [1:0]         b_idx;
    logic [15:0]        a_h, b_h;
    logic [7:0]         a_b, b_b;
    logic signed [16:0] a_lane, b_lane;
    logic [31:0]        lane_prod;
    logic               lane_ov, last_lane;

    assign info_q = decode_op(op_q);

    // X variants read b lanes in swapped pairs (1,0,3,2 for bytes; 1,0 for halves).
    assign b_idx = {cnt_q[1], cnt_q[0] ^ info_q.swap};
    assign a_h   = a_q[{cnt_q[0], 4'd0} +: 16];
    assign b_h   = b_q[{b_idx[0], 4'd0} +: 16];
    assign a_b   = a_q[{cnt_q, 3'd0} +: 8];
    assign b_b   = b_q[{b_idx, 3'd0} +: 8];

    assign a_lane = info_q.lane16 ? {info_q.is_signed & a_h[15], a_h}
                                  : {{9{info_q.is_signed & a_b[7]}}, a_b};
    assign b_lane = info_q.lane16 ? {info_q.is_signed & b_h[15], b_h}
                                  : {{9{info_q.is_signed & b_b[7]}}, b_b};

    ibex_pext_lane_mul u_lane_mul (
        .a_i      (a_lane),
        .b_i      (b_lane),
        .mode16_i (info_q.lane16),
        .shift_i  (info_q.khm),
        .prod_o   (lane_prod),
        .ov_o     (lane_ov)
    );

    assign last_lane = info_q.lane16 ? (cnt_q == 2'(PEXT_LANES16 - 1))
                                     : (cnt_q == 2'(PEXT_LANES8 - 1));

    // KHM lanes keep the element width; plain multiplies double it.
    always_comb begin
        lane_result = result_q;
        if (info_q.khm) begin
            if (info_q.lane16) lane_result[{1'b0, cnt_q[0], 4'd0} +: 16] = lane_prod[15:0];
            else               lane_result[{1'b0, cnt_q, 3'd0} +: 8]     = lane_prod[7:0];
        end else begin
            if (info_q.lane16) lane_result[{cnt_q[0], 5'd0} +: 32]       = lane_prod;
            else               lane_result[{cnt_q, 4'd0} +: 16]          = lane_prod[15:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= ZPN_SMUL16;
            cnt_q    <= 2'd0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ov_q     <= 1'b0;
            wide_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            ov_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q     <= operator_i;
                        a_q      <= operand_a_i;
                        b_q      <= operand_b_i;
                        result_q <= '0;
                        ov_q     <= 1'b0;
                        cnt_q    <= 2'd0;
                        wide_q   <= op_wide(operator_i);
                        state_q  <= op_supported(operator_i) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    result_q <= lane_result;
                    ov_q     <= ov_q | lane_ov;
                    cnt_q    <= cnt_q + 2'd1;
                    if (last_lane) begin
                        cnt_q   <= 2'd0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
    assign wide_o   = wide_q;
    assign set_ov_o = valid_o & ov_q;

endmodule
